// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage core. It owns every stall
// and flush decision. It produces register enables for PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB, plus bubble strobes for IF/ID, ID/EX and MEM/WB. The
// hazards it resolves are load-use, taken-branch redirect, instruction-fetch
// wait and data-memory wait.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   MemRead_EX_i, rd_addr_EX_i    load in EX and its destination register
//   rs1/rs2_addr_ID_i, *_used_ID_i  ID-stage source registers and use flags
//   branch_taken_EX_i             taken branch/jump resolved in EX
//   imem_ready_i                  fetch data valid this cycle
//   dmem_req_MEM_i, dmem_ready_i  MEM-stage access in progress / completing
//   pc_en_o, *_en_o               register enables
//   *_flush_o                     load a bubble (flush beats enable)
//   mem_err_o                     one-cycle pulse on data-memory timeout
//   stall_cnt_o, flush_cnt_o, dmem_wait_cnt_o  performance counters
//
// Configuration macro: HAZARD_PERF_CNT_EN builds the performance counters.
// Without it the three counter ports are tied to zero.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      MemRead_EX_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_EX_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_ID_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_ID_i,
  input  logic                      rs1_used_ID_i,
  input  logic                      rs2_used_ID_i,
  input  logic                      branch_taken_EX_i,
  input  logic                      imem_ready_i,
  input  logic                      dmem_req_MEM_i,
  input  logic                      dmem_ready_i,
  output logic                      pc_en_o,
  output logic                      if_id_en_o,
  output logic                      id_ex_en_o,
  output logic                      ex_mem_en_o,
  output logic                      mem_wb_en_o,
  output logic                      if_id_flush_o,
  output logic                      id_ex_flush_o,
  output logic                      mem_wb_flush_o,
  output logic                      mem_err_o,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               flush_cnt_o,
  output logic [31:0]               dmem_wait_cnt_o
);

  localparam int TIMER_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_DMEM_WAIT   = 2'd1,
    ST_IFETCH_DROP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TIMER_W-1:0]   r_timer;
  logic [TIMER_W-1:0]   w_timer_nxt;
  logic                 w_load_use;
  logic                 w_dstall;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign w_load_use = MemRead_EX_i && (rd_addr_EX_i != '0) &&
                      ((rs1_used_ID_i && (rd_addr_EX_i == rs1_addr_ID_i)) ||
                       (rs2_used_ID_i && (rd_addr_EX_i == rs2_addr_ID_i)));

  assign w_dstall = dmem_req_MEM_i && !dmem_ready_i;

  // Output and next-state decode. DMEM_WAIT with ready behaves exactly like
  // RUN, because dstall is necessarily false then. Reset forces every strobe
  // low, independent of the clock.
  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    id_ex_en_o     = 1'b1;
    ex_mem_en_o    = 1'b1;
    mem_wb_en_o    = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    mem_wb_flush_o = 1'b0;
    mem_err_o      = 1'b0;
    w_state_nxt    = r_state;
    w_timer_nxt    = '0;

    if (r_state == ST_DMEM_WAIT && !dmem_ready_i) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_en_o    = 1'b0;
      mem_wb_en_o    = 1'b0;
      mem_wb_flush_o = 1'b1;
      if (r_timer == TIMER_LAST) begin
        mem_err_o   = 1'b1;
        w_timer_nxt = '0;
      end else begin
        w_timer_nxt = r_timer + TIMER_W'(1);
      end
    end else if (r_state == ST_IFETCH_DROP) begin
      // The outstanding wrong-path word is discarded whenever it arrives.
      pc_en_o       = imem_ready_i;
      if_id_flush_o = 1'b1;
      if (w_dstall) begin
        id_ex_en_o     = 1'b0;
        ex_mem_en_o    = 1'b0;
        mem_wb_en_o    = 1'b0;
        mem_wb_flush_o = 1'b1;
        w_state_nxt    = imem_ready_i ? ST_DMEM_WAIT : ST_IFETCH_DROP;
      end else begin
        w_state_nxt    = imem_ready_i ? ST_RUN : ST_IFETCH_DROP;
      end
    end else begin
      // Branch and load-use are ignored under a data stall; EX is frozen,
      // so they are seen again once memory completes.
      if (w_dstall) begin
        pc_en_o        = 1'b0;
        if_id_en_o     = 1'b0;
        id_ex_en_o     = 1'b0;
        ex_mem_en_o    = 1'b0;
        mem_wb_en_o    = 1'b0;
        mem_wb_flush_o = 1'b1;
        w_state_nxt    = ST_DMEM_WAIT;
      end else if (branch_taken_EX_i) begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
        w_state_nxt   = imem_ready_i ? ST_RUN : ST_IFETCH_DROP;
      end else if (w_load_use) begin
        pc_en_o       = 1'b0;
        if_id_en_o    = 1'b0;
        id_ex_flush_o = 1'b1;
        w_state_nxt   = ST_RUN;
      end else if (!imem_ready_i) begin
        pc_en_o       = 1'b0;
        if_id_flush_o = 1'b1;
        w_state_nxt   = ST_RUN;
      end else begin
        w_state_nxt   = ST_RUN;
      end
    end

    if (!rst_n) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_en_o    = 1'b0;
      mem_wb_en_o    = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      mem_wb_flush_o = 1'b0;
      mem_err_o      = 1'b0;
    end
  end

  // State and timeout timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] r_dmem_wait_cnt;

  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt     <= '0;
      r_flush_cnt     <= '0;
      r_dmem_wait_cnt <= '0;
    end else begin
      if (!pc_en_o)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (if_id_flush_o || id_ex_flush_o)
        r_flush_cnt <= r_flush_cnt + 32'd1;
      if (r_state == ST_DMEM_WAIT)
        r_dmem_wait_cnt <= r_dmem_wait_cnt + 32'd1;
    end
  end

  assign stall_cnt_o     = r_stall_cnt;
  assign flush_cnt_o     = r_flush_cnt;
  assign dmem_wait_cnt_o = r_dmem_wait_cnt;
`else
  assign stall_cnt_o     = 32'd0;
  assign flush_cnt_o     = 32'd0;
  assign dmem_wait_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Scenario-driven bench for hazard_ctrl. Each task builds a list of cycles,
// and each cycle pairs its inputs with the expected strobe vector. Inputs are
// driven just after the rising edge. The expectation is pushed to a
// scoreboard queue at the same time, then popped and compared on the
// falling edge.
// Strobe vector bit order: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
// if_id_flush, id_ex_flush, mem_wb_flush, mem_err.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic [8:0] EXP_ZERO     = 9'b00000_000_0;
  localparam logic [8:0] EXP_RUN      = 9'b11111_000_0;
  localparam logic [8:0] EXP_LU       = 9'b00111_010_0;
  localparam logic [8:0] EXP_BR       = 9'b11111_110_0;
  localparam logic [8:0] EXP_IMISS    = 9'b01111_100_0;
  localparam logic [8:0] EXP_FRZ      = 9'b00000_001_0;
  localparam logic [8:0] EXP_ERR      = 9'b00000_001_1;
  localparam logic [8:0] EXP_DROPFRZ  = 9'b01000_101_0;
  localparam logic [8:0] EXP_DROPDONE = 9'b11111_100_0;

  logic        clk;
  logic        rst_n;
  logic        memRead;
  logic [4:0]  rdAddr;
  logic [4:0]  rs1Addr;
  logic [4:0]  rs2Addr;
  logic        rs1Used;
  logic        rs2Used;
  logic        branchTaken;
  logic        imemReady;
  logic        dmemReq;
  logic        dmemReady;
  logic        pcEn, ifIdEn, idExEn, exMemEn, memWbEn;
  logic        ifIdFlush, idExFlush, memWbFlush, memErr;
  logic [31:0] stallCnt, flushCnt, dmemWaitCnt;
  logic [8:0]  obs;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    string      tag;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic       im;
    logic       dq;
    logic       dr;
    logic [8:0] exp;
  } step_t;

  logic [8:0] expQ[$];
  string      tagQ[$];

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .MemRead_EX_i      (memRead),
    .rd_addr_EX_i      (rdAddr),
    .rs1_addr_ID_i     (rs1Addr),
    .rs2_addr_ID_i     (rs2Addr),
    .rs1_used_ID_i     (rs1Used),
    .rs2_used_ID_i     (rs2Used),
    .branch_taken_EX_i (branchTaken),
    .imem_ready_i      (imemReady),
    .dmem_req_MEM_i    (dmemReq),
    .dmem_ready_i      (dmemReady),
    .pc_en_o           (pcEn),
    .if_id_en_o        (ifIdEn),
    .id_ex_en_o        (idExEn),
    .ex_mem_en_o       (exMemEn),
    .mem_wb_en_o       (memWbEn),
    .if_id_flush_o     (ifIdFlush),
    .id_ex_flush_o     (idExFlush),
    .mem_wb_flush_o    (memWbFlush),
    .mem_err_o         (memErr),
    .stall_cnt_o       (stallCnt),
    .flush_cnt_o       (flushCnt),
    .dmem_wait_cnt_o   (dmemWaitCnt)
  );

  assign obs = {pcEn, ifIdEn, idExEn, exMemEn, memWbEn,
                ifIdFlush, idExFlush, memWbFlush, memErr};

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic step_t mk(string tag, logic mr, int rd, int rs1, int rs2,
                               logic u1, logic u2, logic br, logic im,
                               logic dq, logic dr, logic [8:0] exp);
    step_t s;
    s.tag = tag;
    s.mr  = mr;
    s.rd  = 5'(rd);
    s.rs1 = 5'(rs1);
    s.rs2 = 5'(rs2);
    s.u1  = u1;
    s.u2  = u2;
    s.br  = br;
    s.im  = im;
    s.dq  = dq;
    s.dr  = dr;
    s.exp = exp;
    return s;
  endfunction

  // Drive one cycle of inputs and record what the strobes must be.
  task automatic applyStimulus(input step_t s);
    memRead     = s.mr;
    rdAddr      = s.rd;
    rs1Addr     = s.rs1;
    rs2Addr     = s.rs2;
    rs1Used     = s.u1;
    rs2Used     = s.u2;
    branchTaken = s.br;
    imemReady   = s.im;
    dmemReq     = s.dq;
    dmemReady   = s.dr;
    expQ.push_back(s.exp);
    tagQ.push_back(s.tag);
  endtask

  task automatic setIdle();
    memRead = 0; rdAddr = 0; rs1Addr = 0; rs2Addr = 0;
    rs1Used = 0; rs2Used = 0; branchTaken = 0;
    imemReady = 1; dmemReq = 0; dmemReady = 1;
  endtask

  // Leaves time at rising edge + 1 with reset released.
  task automatic doReset();
    @(posedge clk); #1;
    setIdle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step_t s;
    $display("[TB] test_reset");
    rst_n = 1'b0;
    s = mk("reset_hold", 1, 5, 5, 5, 1, 1, 1, 0, 1, 0, EXP_ZERO);
    applyStimulus(s);
    #3;
    assertCount++;
    if (obs !== expQ.pop_front()) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b", tagQ[0], obs, EXP_ZERO);
    end
    void'(tagQ.pop_front());
    assertCount++;
    if ({stallCnt, flushCnt, dmemWaitCnt} !== 96'd0) begin
      failCount++;
      $display("[TB] FAIL reset_counters: got %h %h %h expected 0 0 0",
               stallCnt, flushCnt, dmemWaitCnt);
    end
    doReset();
  endtask

  task automatic test_load_use();
    step_t s[$];
    logic [8:0] expV;
    string tag;
    $display("[TB] test_load_use");
    doReset();
    s.push_back(mk("lu_rs2",      1, 5, 3, 5, 1, 1, 0, 1, 0, 1, EXP_LU));
    s.push_back(mk("lu_rs2_next", 0, 0, 3, 5, 1, 1, 0, 1, 0, 1, EXP_RUN));
    s.push_back(mk("lu_rs1",      1, 7, 7, 2, 1, 1, 0, 1, 0, 1, EXP_LU));
    s.push_back(mk("lu_rs1_next", 0, 0, 7, 2, 1, 1, 0, 1, 0, 1, EXP_RUN));
    s.push_back(mk("lu_unused",   1, 9, 9, 4, 0, 1, 0, 1, 0, 1, EXP_RUN));
    s.push_back(mk("not_load",    0, 5, 5, 5, 1, 1, 0, 1, 0, 1, EXP_RUN));
    s.push_back(mk("load_x0",     1, 0, 0, 0, 1, 1, 0, 1, 0, 1, EXP_RUN));
    // Random operand mix over a small register range to hit matches often.
    for (int i = 0; i < 20; i++) begin
      int rd, r1, r2;
      logic mr, u1, u2, lu;
      rd = $urandom_range(0, 3); r1 = $urandom_range(0, 3); r2 = $urandom_range(0, 3);
      mr = 1'($urandom_range(0, 1)); u1 = 1'($urandom_range(0, 1)); u2 = 1'($urandom_range(0, 1));
      lu = mr && (rd != 0) && ((u1 && rd == r1) || (u2 && rd == r2));
      s.push_back(mk($sformatf("lu_rand%0d", i), mr, rd, r1, r2, u1, u2, 0, 1, 0, 1,
                     lu ? EXP_LU : EXP_RUN));
    end
    foreach (s[i]) begin
      applyStimulus(s[i]);
      @(negedge clk);
      expV = expQ.pop_front(); tag = tagQ.pop_front();
      assertCount++;
      if (obs !== expV) begin
        failCount++;
        $display("[TB] FAIL %s: got %b expected %b", tag, obs, expV);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_ifetch();
    step_t s[$];
    logic [8:0] expV;
    string tag;
    $display("[TB] test_branch_ifetch");
    doReset();
    s.push_back(mk("br_imiss",    0, 0, 0, 0, 0, 0, 1, 0, 0, 1, EXP_BR));
    s.push_back(mk("drop_1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, EXP_IMISS));
    s.push_back(mk("drop_2",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, EXP_IMISS));
    s.push_back(mk("drop_3",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, EXP_IMISS));
    s.push_back(mk("drop_done",   0, 0, 0, 0, 0, 0, 0, 1, 0, 1, EXP_DROPDONE));
    s.push_back(mk("after_drop",  0, 0, 0, 0, 0, 0, 0, 1, 0, 1, EXP_RUN));
    s.push_back(mk("br_hit",      0, 0, 0, 0, 0, 0, 1, 1, 0, 1, EXP_BR));
    s.push_back(mk("after_brhit", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, EXP_RUN));
    s.push_back(mk("imiss_run",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, EXP_IMISS));
    s.push_back(mk("after_imiss", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, EXP_RUN));
    s.push_back(mk("br_over_lu",  1, 5, 5, 0, 1, 0, 1, 1, 0, 1, EXP_BR));
    s.push_back(mk("lu_over_im",  1, 5, 5, 0, 1, 0, 0, 0, 0, 1, EXP_LU));
    s.push_back(mk("im_after_lu", 0, 0, 5, 0, 1, 0, 0, 0, 0, 1, EXP_IMISS));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      @(negedge clk);
      expV = expQ.pop_front(); tag = tagQ.pop_front();
      assertCount++;
      if (obs !== expV) begin
        failCount++;
        $display("[TB] FAIL %s: got %b expected %b", tag, obs, expV);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dmem_branch();
    step_t s[$];
    logic [8:0] expV;
    string tag;
    $display("[TB] test_dmem_branch");
    doReset();
    for (int i = 0; i < 5; i++)
      s.push_back(mk($sformatf("dfrz_br%0d", i), 1, 5, 5, 0, 1, 0, 1, 1, 1, 0, EXP_FRZ));
    s.push_back(mk("dready_br",  0, 0, 0, 0, 0, 0, 1, 1, 1, 1, EXP_BR));
    s.push_back(mk("after_br",   0, 0, 0, 0, 0, 0, 0, 1, 0, 1, EXP_RUN));
    s.push_back(mk("d_then_lu",  1, 6, 0, 6, 0, 1, 0, 1, 1, 0, EXP_FRZ));
    s.push_back(mk("dready_lu",  1, 6, 0, 6, 0, 1, 0, 1, 1, 1, EXP_LU));
    s.push_back(mk("lu_clear",   0, 0, 0, 6, 0, 1, 0, 1, 0, 1, EXP_RUN));
    s.push_back(mk("br_miss2",   0, 0, 0, 0, 0, 0, 1, 0, 0, 1, EXP_BR));
    s.push_back(mk("drop_dstl",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EXP_DROPFRZ));
    s.push_back(mk("drop_dstl2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EXP_DROPFRZ));
    s.push_back(mk("drop_keep",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, EXP_IMISS));
    s.push_back(mk("drop_done2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, EXP_DROPDONE));
    s.push_back(mk("run_again",  0, 0, 0, 0, 0, 0, 0, 1, 0, 1, EXP_RUN));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      @(negedge clk);
      expV = expQ.pop_front(); tag = tagQ.pop_front();
      assertCount++;
      if (obs !== expV) begin
        failCount++;
        $display("[TB] FAIL %s: got %b expected %b", tag, obs, expV);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    step_t s[$];
    logic [8:0] expV;
    string tag;
    $display("[TB] test_timeout");
    doReset();
    // Cycle 1 enters the wait; wait-state cycles 16 and 32 are cycles 17 and 33.
    for (int c = 1; c <= 40; c++)
      s.push_back(mk($sformatf("tmo_c%0d", c), 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,
                     (c == 17 || c == 33) ? EXP_ERR : EXP_FRZ));
    s.push_back(mk("tmo_ready", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, EXP_RUN));
    s.push_back(mk("tmo_after", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, EXP_RUN));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      @(negedge clk);
      expV = expQ.pop_front(); tag = tagQ.pop_front();
      assertCount++;
      if (obs !== expV) begin
        failCount++;
        $display("[TB] FAIL %s: got %b expected %b", tag, obs, expV);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    assertCount++;
`ifdef HAZARD_PERF_CNT_EN
    if (dmemWaitCnt !== 32'd40 || stallCnt !== 32'd40 || flushCnt !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL tmo_counters: got wait=%0d stall=%0d flush=%0d expected 40 40 0",
               dmemWaitCnt, stallCnt, flushCnt);
    end
`else
    if ({stallCnt, flushCnt, dmemWaitCnt} !== 96'd0) begin
      failCount++;
      $display("[TB] FAIL tmo_counters: got %0d %0d %0d expected 0 0 0",
               stallCnt, flushCnt, dmemWaitCnt);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    step_t s[$];
    logic [8:0] expV;
    string tag;
    $display("[TB] test_reset_mid_wait");
    doReset();
    for (int i = 0; i < 4; i++)
      s.push_back(mk($sformatf("pre_rst%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, EXP_FRZ));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      @(negedge clk);
      expV = expQ.pop_front(); tag = tagQ.pop_front();
      assertCount++;
      if (obs !== expV) begin
        failCount++;
        $display("[TB] FAIL %s: got %b expected %b", tag, obs, expV);
      end
      @(posedge clk); #1;
    end
    // Assert reset between edges while the memory is still stalled.
    rst_n = 1'b0;
    #1;
    assertCount++;
    if (obs !== EXP_ZERO) begin
      failCount++;
      $display("[TB] FAIL rst_async: got %b expected %b", obs, EXP_ZERO);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    s.delete();
    // A stuck DMEM_WAIT would freeze here with ready low; RUN must not.
    for (int i = 0; i < 3; i++)
      s.push_back(mk($sformatf("post_rst%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, EXP_RUN));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      @(negedge clk);
      expV = expQ.pop_front(); tag = tagQ.pop_front();
      assertCount++;
      if (obs !== expV) begin
        failCount++;
        $display("[TB] FAIL %s: got %b expected %b", tag, obs, expV);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    setIdle();
    rst_n = 1'b0;
    #2;
    test_reset();
    test_load_use();
    test_branch_ifetch();
    test_dmem_branch();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
